// File: rtl/fb_arb_pkg.sv
// Shared types and sizing helpers for the frame-buffer arbiter and its write FIFO.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_t;

  localparam int RD_LATENCY = 3;

  function automatic int fb_depth(input int cols, input int rows);
    return cols * rows;
  endfunction

  function automatic int fb_addr_w(input int cols, input int rows);
    return $clog2(cols * rows);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; push is ignored when full,
// pop is ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guards use the registered count, so a full FIFO refuses a push even on a pop cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer arbiter: fixed-latency scan-out reads always win,
// camera writes are queued and drained into idle RAM cycles.
module frame_buffer_arbiter
  import fb_arb_pkg::*;
#(
  parameter int DATA_W         = 12,
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int WR_FIFO_DEPTH  = 8,
  parameter int STARVE_LIMIT   = 64,
  localparam int FB_DEPTH      = fb_depth(ACTIVE_COLUMNS, ACTIVE_ROWS),
  localparam int ADDR_W        = fb_addr_w(ACTIVE_COLUMNS, ACTIVE_ROWS)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_drop_o,
  output logic              wr_starve_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int FIFO_W   = ADDR_W + DATA_W;
  localparam int CNT_W    = $clog2(WR_FIFO_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int PIPE_W   = RD_LATENCY - 1;

  grant_t              grant_q, grant_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [PIPE_W-1:0]   rd_pipe_q, rd_pipe_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                wr_drop_q, wr_drop_d;
  logic                wr_starve_q, wr_starve_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                wr_ready_en_q;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0]   fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                wr_fire, wr_in_range;

  // Widened compare keeps FB_DEPTH exact even when it is a power of two.
  assign wr_in_range = ({1'b0, wr_addr_i} < (ADDR_W + 1)'(FB_DEPTH));
  assign wr_ready_o  = wr_ready_en_q & ~fifo_full;
  assign wr_fire     = wr_valid_i & wr_ready_o;
  assign fifo_push   = wr_fire & wr_in_range;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (WR_FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (fifo_push),
    .wdata_i  ({wr_addr_i, wr_data_i}),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  always_comb begin
    grant_d      = GNT_IDLE;
    fifo_pop     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if (rd_req_i) begin
      grant_d    = GNT_READ;
      mem_addr_d = rd_addr_i;
    end else if (!fifo_empty) begin
      grant_d     = GNT_WRITE;
      fifo_pop    = 1'b1;
      mem_addr_d  = fifo_head[FIFO_W-1:DATA_W];
      mem_wdata_d = fifo_head[DATA_W-1:0];
    end

    rd_pipe_d  = {rd_pipe_q[PIPE_W-2:0], rd_req_i};
    rd_valid_d = rd_pipe_q[PIPE_W-1];
    rd_data_d  = rd_pipe_q[PIPE_W-1] ? mem_rdata_i : rd_data_q;

    wr_drop_d = wr_fire & ~wr_in_range;

    // Counts cycles the head is blocked; saturates so the sticky flag never re-arms.
    starve_cnt_d = starve_cnt_q;
    if (fifo_count == '0 || fifo_pop) starve_cnt_d = '0;
    else if (starve_cnt_q < STARVE_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
    wr_starve_d = wr_starve_q | (starve_cnt_d == STARVE_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      grant_q       <= GNT_IDLE;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_pipe_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      wr_drop_q     <= 1'b0;
      wr_starve_q   <= 1'b0;
      starve_cnt_q  <= '0;
      wr_ready_en_q <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_pipe_q     <= rd_pipe_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      wr_drop_q     <= wr_drop_d;
      wr_starve_q   <= wr_starve_d;
      starve_cnt_q  <= starve_cnt_d;
      wr_ready_en_q <= 1'b1;
    end
  end

  // RAM strobes decode straight from the registered grant.
  assign mem_en_o    = (grant_q != GNT_IDLE);
  assign mem_we_o    = (grant_q == GNT_WRITE);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign wr_drop_o   = wr_drop_q;
  assign wr_starve_o = wr_starve_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural single-port RAM.
module tb_frame_buffer_arbiter;

  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 19;
  localparam int FB_DEPTH = 307200;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_drop_o;
  logic              wr_starve_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] ram [FB_DEPTH];
  int                rd_valid_cnt = 0;
  int                we_cnt = 0;
  int                cyc = 0;
  logic [ADDR_W-1:0] wq_addr [$];
  logic [DATA_W-1:0] wq_data [$];
  int                wq_cyc  [$];

  always #5 clk_i = ~clk_i;

  frame_buffer_arbiter dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .rd_req_i    (rd_req_i),
    .rd_addr_i   (rd_addr_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .wr_drop_o   (wr_drop_o),
    .wr_starve_o (wr_starve_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i <= ram[mem_addr_o];
    end
  end

  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    if (rd_valid_o) rd_valid_cnt <= rd_valid_cnt + 1;
    if (mem_en_o && mem_we_o) begin
      we_cnt <= we_cnt + 1;
      wq_addr.push_back(mem_addr_o);
      wq_data.push_back(mem_wdata_o);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {rd_valid_o, wr_ready_o, wr_drop_o, wr_starve_o, mem_en_o, mem_we_o}
           | 32'(rd_data_o) | 32'(mem_addr_o) | 32'(mem_wdata_o);
  endfunction

  task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    rd_req_i  = 1'b1;
    rd_addr_i = a;
    tick();
    rd_req_i  = 1'b0;
    tick();
    tick();
    check({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
    check({tag, "_data"}, 32'(rd_data_o), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, rv0;
    reset_ni   = 1'b0;
    rd_req_i   = 1'b0;
    rd_addr_i  = '0;
    wr_valid_i = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    ram[1234]  = 12'hABC;
    ram[2000]  = 12'h111;

    // 1: reset state and ready after release
    repeat (5) tick();
    check("reset_outs_zero", all_outs(), 32'd0);
    reset_ni = 1'b1;
    check("ready_low_at_release", 32'(wr_ready_o), 32'd0);
    tick();
    check("ready_after_release", 32'(wr_ready_o), 32'd1);
    check("idle_no_mem_en", 32'(mem_en_o), 32'd0);

    // 2: single read, latency 3
    we0 = we_cnt;
    rd_req_i  = 1'b1;
    rd_addr_i = 19'd1234;
    tick();
    rd_req_i  = 1'b0;
    check("rd_mem_en", 32'(mem_en_o), 32'd1);
    check("rd_mem_we", 32'(mem_we_o), 32'd0);
    check("rd_mem_addr", 32'(mem_addr_o), 32'd1234);
    tick();
    check("rd_valid_not_early", 32'(rd_valid_o), 32'd0);
    tick();
    check("rd_valid_at_3", 32'(rd_valid_o), 32'd1);
    check("rd_data_at_3", 32'(rd_data_o), 32'hABC);
    tick();
    check("rd_valid_pulse", 32'(rd_valid_o), 32'd0);
    check("rd_data_holds", 32'(rd_data_o), 32'hABC);
    check("rd_no_writes", 32'(we_cnt - we0), 32'd0);

    // 3: fill FIFO while reads hold the port, then drain in order
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    rd_req_i  = 1'b1;
    rd_addr_i = 19'd1234;
    for (int i = 0; i < 8; i++) begin
      wr_valid_i = 1'b1;
      wr_addr_i  = 19'(100 + i);
      wr_data_i  = 12'(12'h300 + 12'(i * 17));
      tick();
    end
    wr_valid_i = 1'b0;
    check("fifo_full_ready_low", 32'(wr_ready_o), 32'd0);
    rd_req_i = 1'b0;
    repeat (12) tick();
    check("drain_ready_back", 32'(wr_ready_o), 32'd1);
    check("drain_count", 32'(wq_addr.size()), 32'd8);
    if (wq_addr.size() == 8) begin
      check("drain_back_to_back", 32'(wq_cyc[7] - wq_cyc[0]), 32'd7);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("drain_addr%0d", i), 32'(wq_addr[i]), 32'(100 + i));
        check($sformatf("drain_data%0d", i), 32'(wq_data[i]), 32'(12'h300 + 12'(i * 17)));
      end
    end
    do_read("readback0", 19'd100, 12'h300);
    do_read("readback7", 19'd107, 12'(12'h300 + 12'd119));

    // 4: continuous reads starve a queued write
    repeat (3) tick();
    we0 = we_cnt;
    rv0 = rd_valid_cnt;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    check("starve_clear_before", 32'(wr_starve_o), 32'd0);
    rd_req_i   = 1'b1;
    rd_addr_i  = 19'd1234;
    wr_valid_i = 1'b1;
    wr_addr_i  = 19'd2000;
    wr_data_i  = 12'h5A5;
    tick();
    wr_valid_i = 1'b0;
    for (int i = 1; i < 70; i++) begin
      if (i == 40) check("starve_low_at_wait39", 32'(wr_starve_o), 32'd0);
      tick();
    end
    rd_req_i = 1'b0;
    check("starve_no_write_during_reads", 32'(we_cnt - we0), 32'd0);
    check("starve_flag_set", 32'(wr_starve_o), 32'd1);
    repeat (3) tick();
    check("starve_all_reads_valid", 32'(rd_valid_cnt - rv0), 32'd70);
    check("starve_last_rd_data", 32'(rd_data_o), 32'hABC);
    tick();
    check("starve_write_landed", 32'(we_cnt - we0), 32'd1);
    if (wq_addr.size() == 1) check("starve_write_addr", 32'(wq_addr[0]), 32'd2000);
    do_read("starve_readback", 19'd2000, 12'h5A5);

    // 5: out-of-range write is accepted and dropped
    we0 = we_cnt;
    wr_valid_i = 1'b1;
    wr_addr_i  = 19'(FB_DEPTH);
    wr_data_i  = 12'hFFF;
    check("drop_ready", 32'(wr_ready_o), 32'd1);
    tick();
    wr_valid_i = 1'b0;
    check("drop_pulse", 32'(wr_drop_o), 32'd1);
    tick();
    check("drop_pulse_end", 32'(wr_drop_o), 32'd0);
    repeat (4) tick();
    check("drop_no_ram_write", 32'(we_cnt - we0), 32'd0);
    check("starve_sticky", 32'(wr_starve_o), 32'd1);

    // 6: reset mid-burst clears everything, nothing leaks afterwards
    rd_req_i  = 1'b1;
    rd_addr_i = 19'd1234;
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1;
      wr_addr_i  = 19'(3000 + i);
      wr_data_i  = 12'(i + 1);
      tick();
    end
    wr_valid_i = 1'b0;
    rd_req_i   = 1'b0;
    reset_ni   = 1'b0;
    #1;
    check("midreset_outs_zero", all_outs(), 32'd0);
    we0 = we_cnt;
    rv0 = rd_valid_cnt;
    repeat (2) tick();
    reset_ni = 1'b1;
    repeat (10) tick();
    check("midreset_no_rd_valid", 32'(rd_valid_cnt - rv0), 32'd0);
    check("midreset_fifo_empty", 32'(we_cnt - we0), 32'd0);
    check("midreset_ready", 32'(wr_ready_o), 32'd1);
    check("midreset_starve_cleared", 32'(wr_starve_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
